cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Sits on the far side of every functional unit's result port (o_cdb/o_valid/o_ready) and is the sole driver of the common data bus (cdb/cdb_valid).
- Each cycle it picks one ready result from N_UNITS functional units (ALU, FPU, load/store, ...) using round-robin.
- It returns a one-hot ready to the winner and broadcasts the winner's {rsv_id, data} word, registered, to all reservation stations and the reorder logic.

Parameters:
N_UNITS, 4, number of functional-unit result ports (>= 2)
PTR_W, $clog2(N_UNITS), width of round-robin pointer (derived, not overridable)

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
clear  input  1  synchronous pipeline flush (mispredict)
i_valid  input  N_UNITS  per-unit result valid (FU o_valid)
i_cdb  input  N_UNITS*CDB_W  per-unit result word {rsv_id[RSV_ID_W], data[DATA_W]}; unit k at [k*CDB_W +: CDB_W]
i_ready  output  N_UNITS  per-unit grant (drives FU o_ready)
cdb  output  CDB_W  broadcast word
cdb_valid  output  1  broadcast valid, high exactly one cycle per result

Behaviour:
- Reset (nrst low, asynchronous): cdb = 0, cdb_valid = 0, rr pointer = 0. i_ready = 0 while nrst is low.
- Broadcast bus has no backpressure; every consumer snoops.
- Grant, combinational:
  - Scan i_valid starting at pointer p, in order p, p+1, ..., N_UNITS-1, 0, ..., p-1.
  - The first set bit k wins; i_ready = one-hot(k).
  - No valid: i_ready = 0.
- i_ready may depend combinationally on i_valid. FUs must hold i_valid/i_cdb stable until granted; no combinational path from i_ready back to i_valid.
- Transfer on unit k occurs when i_valid[k] & i_ready[k] at a rising edge. Next cycle: cdb = i_cdb slice k, cdb_valid = 1. Latency is exactly 1 cycle.
- No transfer: cdb_valid = 0 next cycle and cdb holds its last value. Consumers must ignore cdb when cdb_valid is low.
- Pointer update on transfer: p <= (k == N_UNITS-1) ? 0 : k+1. No transfer: p unchanged.
- Fairness: a continuously valid unit is granted within N_UNITS cycles.
- Throughput: one result per cycle, sustained.
- clear high:
  - i_ready = 0, so no transfer.
  - Next cycle: cdb_valid = 0, cdb = 0, p = 0.
  - A broadcast already registered during the clear cycle is still visible that cycle; it is dropped from the following cycle.
- clear and a would-be transfer in the same cycle: clear wins; the FU keeps its result. FUs flush themselves from the same clear.
- Reset mid-broadcast: cdb_valid drops immediately (asynchronous); no partial word is emitted after reset release.
- N_UNITS not a power of two: pointer wrap is explicit, never modulo 2^PTR_W.

Optional Feature:
- Macro CDB_ARB_CONTENTION_CNT_EN.
- Defined:
  - Adds output port contention_cnt [31:0].
  - Increments by 1 each cycle with clear low and popcount(i_valid) >= 2.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0 by nrst and by clear.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- fcpu_pkg already holds CDB_W, RSV_ID_W, DATA_W. Add function cdb_rsv_id(word) and function cdb_data(word) to extract fields; all CDB producers and consumers use them.
- One sub-module: rr_arbiter.
  - Purely combinational.
  - Inputs: req[N], ptr[PTR_W].
  - Outputs: gnt one-hot[N], gnt_idx[PTR_W], any.
  - Reusable later for reservation-station issue selection.
- cdb_arbiter holds the pointer, output register, clear handling and the optional counter.

Test Plan:
- Reset: nrst low while i_valid = 4'b1111 -> i_ready = 0, cdb_valid = 0. After release, first grant is unit 0; next cycle cdb = i_cdb[0], cdb_valid = 1.
- All four valid for 8 cycles, each unit holds valid until granted and re-asserts at once -> grant order 0,1,2,3,0,1,2,3; cdb_valid high all 8 cycles after the first.
- Only unit 2 valid, rsv_id = 3, data = 32'hDEAD_BEEF -> i_ready = 4'b0100 that cycle; next cycle cdb = {3, 32'hDEAD_BEEF}; pointer = 3.
- Pointer = 3, then units 1 and 3 valid -> unit 3 granted first, then unit 1 next cycle; pointer ends at 2.
- clear asserted with unit 1 valid -> i_ready = 0. Next cycle cdb_valid = 0, pointer = 0; unit 1 not consumed (still valid if FU ignores clear).
- With CDB_ARB_CONTENTION_CNT_EN defined: 5 cycles with i_valid = 4'b0011, then 3 cycles with 4'b0001 -> contention_cnt = 5. Then clear -> 0.

Source files
------------

// File: rtl/fcpu_pkg.sv
// Shared CPU-wide widths and helpers for the common data bus word {rsv_id, data}.
// Every CDB producer and consumer extracts fields through these functions.
package fcpu_pkg;

  localparam int RSV_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  typedef logic [CDB_W-1:0] cdb_word_t;

  function automatic logic [RSV_ID_W-1:0] cdb_rsv_id(input cdb_word_t word);
    return word[CDB_W-1 -: RSV_ID_W];
  endfunction

  function automatic logic [DATA_W-1:0] cdb_data(input cdb_word_t word);
    return word[DATA_W-1:0];
  endfunction

  function automatic cdb_word_t cdb_pack(input logic [RSV_ID_W-1:0] rsv_id,
                                         input logic [DATA_W-1:0]   data);
    return {rsv_id, data};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans req from ptr upward with explicit wrap.
// Zero latency; no state and no backpressure of its own.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  int               idx;
  logic [PTR_W-1:0] idx_p;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    idx_p   = '0;
    for (int i = 0; i < N; i++) begin
      // wrap by subtraction so non-power-of-two N never aliases
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      idx_p = PTR_W'(idx);
      if (!any && req[idx_p]) begin
        gnt[idx_p] = 1'b1;
        gnt_idx    = idx_p;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin owner of the common data bus; broadcast is registered, 1-cycle latency.
// Grants (i_ready) are the only backpressure to FUs; CDB_ARB_CONTENTION_CNT_EN adds contention_cnt.
module cdb_arbiter
  import fcpu_pkg::*;
#(
  parameter  int N_UNITS = 4,
  localparam int PTR_W   = $clog2(N_UNITS)
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     clear,
  input  logic [N_UNITS-1:0]       i_valid,
  input  logic [N_UNITS*CDB_W-1:0] i_cdb,
  output logic [N_UNITS-1:0]       i_ready,
  output logic [CDB_W-1:0]         cdb,
  output logic                     cdb_valid
`ifdef CDB_ARB_CONTENTION_CNT_EN
  ,
  output logic [31:0]              contention_cnt
`endif
);

  logic [PTR_W-1:0] ptr;
  logic [N_UNITS-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic             any;
  logic             xfer;
  cdb_word_t        words [N_UNITS];

  for (genvar k = 0; k < N_UNITS; k++) begin : g_unpack
    assign words[k] = i_cdb[k*CDB_W +: CDB_W];
  end

  rr_arbiter #(.N(N_UNITS)) u_rr (
    .req     (i_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // grants are suppressed during reset and flush so no FU believes it was consumed
  assign xfer    = any & ~clear & nrst;
  assign i_ready = xfer ? gnt : '0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr       <= '0;
      cdb       <= '0;
      cdb_valid <= 1'b0;
    end else if (clear) begin
      ptr       <= '0;
      cdb       <= '0;
      cdb_valid <= 1'b0;
    end else if (xfer) begin
      cdb       <= words[gnt_idx];
      cdb_valid <= 1'b1;
      ptr       <= (gnt_idx == PTR_W'(N_UNITS - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end else begin
      cdb_valid <= 1'b0;
    end
  end

`ifdef CDB_ARB_CONTENTION_CNT_EN
  logic multi_req;

  // clearing the lowest set bit leaves something only when two or more are set
  assign multi_req = |(i_valid & (i_valid - N_UNITS'(1)));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      contention_cnt <= '0;
    end else if (clear) begin
      contention_cnt <= '0;
    end else if (multi_req && contention_cnt != 32'hFFFF_FFFF) begin
      contention_cnt <= contention_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter with N_UNITS = 4.
// Contention counter vectors are included when CDB_ARB_CONTENTION_CNT_EN is defined.
module tb_cdb_arbiter;
  import fcpu_pkg::*;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               nrst;
  logic               clear;
  logic [N-1:0]       i_valid;
  logic [N*CDB_W-1:0] i_cdb;
  logic [N-1:0]       i_ready;
  logic [CDB_W-1:0]   cdb;
  logic               cdb_valid;
`ifdef CDB_ARB_CONTENTION_CNT_EN
  logic [31:0]        contention_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_UNITS(N)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .clear     (clear),
    .i_valid   (i_valid),
    .i_cdb     (i_cdb),
    .i_ready   (i_ready),
    .cdb       (cdb),
    .cdb_valid (cdb_valid)
`ifdef CDB_ARB_CONTENTION_CNT_EN
    ,
    .contention_cnt (contention_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int k, input cdb_word_t w);
    i_cdb[k*CDB_W +: CDB_W] = w;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cdb_word_t  exp_w;
    logic [3:0] exp_g;
    logic [31:0] d;

    nrst    = 1'b0;
    clear   = 1'b0;
    i_valid = 4'b1111;
    i_cdb   = '0;
    for (int k = 0; k < N; k++) set_word(k, cdb_pack(4'(k), 32'h1000_0000 + 32'(k)));
    #12;
    chk("rst_ready", i_ready, 4'b0000);
    chk("rst_vld", cdb_valid, 1'b0);
    chk("rst_cdb", cdb, '0);

    // release reset between edges; all four units contend continuously
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < N; k++) set_word(k, cdb_pack(4'(k), 32'hA000_0000 + 32'(c*16 + k)));
      #1;
      exp_g = 4'b0001 << (c % 4);
      chk($sformatf("rr_gnt%0d", c), i_ready, exp_g);
      tick;
      exp_w = cdb_pack(4'(c % 4), 32'hA000_0000 + 32'(c*16 + c % 4));
      chk($sformatf("rr_cdb%0d", c), cdb, exp_w);
      chk($sformatf("rr_vld%0d", c), cdb_valid, 1'b1);
    end

    // idle: valid drops, word holds
    i_valid = 4'b0000;
    #1;
    chk("idle_ready", i_ready, 4'b0000);
    tick;
    chk("idle_vld", cdb_valid, 1'b0);
    chk("idle_hold", cdb, cdb_pack(4'd3, 32'hA000_0073));

    // lone unit 2 with a known tag; pointer then sits at 3
    i_valid = 4'b0100;
    set_word(2, cdb_pack(4'd3, 32'hDEAD_BEEF));
    #1;
    chk("u2_ready", i_ready, 4'b0100);
    tick;
    chk("u2_cdb", cdb, 36'h3_DEAD_BEEF);
    chk("u2_rsv", cdb_rsv_id(cdb), 4'd3);
    chk("u2_data", cdb_data(cdb), 32'hDEAD_BEEF);

    // pointer 3 with units 1 and 3: 3 first, then 1
    set_word(1, cdb_pack(4'd9, 32'h1111_0001));
    set_word(3, cdb_pack(4'd7, 32'h3333_0003));
    i_valid = 4'b1010;
    #1;
    chk("p3_first", i_ready, 4'b1000);
    tick;
    chk("p3_cdb3", cdb, 36'h7_3333_0003);
    i_valid = 4'b0010;
    #1;
    chk("p3_second", i_ready, 4'b0010);
    tick;
    chk("p3_cdb1", cdb, 36'h9_1111_0001);
    chk("p3_vld", cdb_valid, 1'b1);
    i_valid = 4'b1011;
    #1;
    chk("ptr_is_2", i_ready, 4'b1000);

    // flush while unit 1 is waiting
    i_valid = 4'b0010;
    clear   = 1'b1;
    #1;
    chk("clr_ready", i_ready, 4'b0000);
    chk("clr_prev_vld", cdb_valid, 1'b1);
    tick;
    clear = 1'b0;
    chk("clr_vld", cdb_valid, 1'b0);
    chk("clr_cdb", cdb, '0);
    i_valid = 4'b1010;
    #1;
    chk("clr_ptr0", i_ready, 4'b0010);
    tick;
    chk("clr_u1_kept", cdb, 36'h9_1111_0001);
    chk("clr_u1_vld", cdb_valid, 1'b1);

    // asynchronous reset while a broadcast is on the bus
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_vld", cdb_valid, 1'b0);
    chk("arst_cdb", cdb, '0);
    chk("arst_ready", i_ready, 4'b0000);
    i_valid = 4'b0000;
    @(negedge clk);
    nrst = 1'b1;

`ifdef CDB_ARB_CONTENTION_CNT_EN
    chk("cnt_rst", contention_cnt, 32'd0);
    i_valid = 4'b0011;
    repeat (5) tick;
    i_valid = 4'b0001;
    repeat (3) tick;
    chk("cnt_five", contention_cnt, 32'd5);
    i_valid = 4'b0000;
    clear   = 1'b1;
    tick;
    clear = 1'b0;
    chk("cnt_clr", contention_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
